// File: rtl/rx_line_writer.sv
// rx_line_writer
//   Assembles bytes from a UART receiver into a NUL-terminated line held in
//   a BRAM region starting at Base. Accepted characters are echoed back
//   towards the UART transmitter, backspace removes the last character, and
//   a CR or LF closes the line, reporting its length.
//
// Parameters
//   AddrBits  width of the BRAM address bus and of LEN
//   Base      first BRAM address of the line buffer
//   Depth     buffer size in bytes including the NUL terminator
//
// Ports
//   CLK        system clock, all logic on posedge
//   RST        synchronous reset, active-high
//   RXDATA     received byte
//   RXVALID    one-cycle strobe qualifying RXDATA
//   ADDR       BRAM address (registered)
//   WR         BRAM write enable, one-cycle pulse
//   DIN        BRAM write data
//   TXDATA     echo byte towards the transmitter
//   TXVALID    echo byte pending
//   TXRDY      transmitter can accept a byte
//   LINE_DONE  one-cycle pulse when a line terminator is written
//   LEN        character count of the last completed line (no NUL)
//   OVF        sticky flag: characters were dropped in this or the last line

module rx_line_writer #(
  parameter int AddrBits = 19,
  parameter int Base     = 0,
  parameter int Depth    = 256
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [7:0]          RXDATA,
  input  logic                RXVALID,
  output logic [AddrBits-1:0] ADDR,
  output logic                WR,
  output logic [7:0]          DIN,
  output logic [7:0]          TXDATA,
  output logic                TXVALID,
  input  logic                TXRDY,
  output logic                LINE_DONE,
  output logic [AddrBits-1:0] LEN,
  output logic                OVF
);

  localparam logic [AddrBits-1:0] base_addr = AddrBits'(Base);
  // Highest character index; the slot at this index is reserved for the NUL.
  localparam logic [AddrBits-1:0] last_idx  = AddrBits'(Depth - 1);

  localparam logic [7:0] ch_nul = 8'h00;
  localparam logic [7:0] ch_bs  = 8'h08;
  localparam logic [7:0] ch_lf  = 8'h0A;
  localparam logic [7:0] ch_cr  = 8'h0D;

  logic [AddrBits-1:0] count;
  // Set between a terminator (or reset) and the first accepted character of
  // the following line; that character is what clears a sticky OVF.
  logic                new_line;

  logic is_nul;
  logic is_bs;
  logic is_term;
  logic is_ord;
  logic has_chars;
  logic has_room;
  logic accept_ord;
  logic drop_ord;
  logic do_bs;
  logic do_term;
  logic echo_req;
  logic [7:0] echo_byte;
  logic xfer;

  // Byte classification and the per-strobe decision. Every strobe resolves
  // in the cycle it arrives, so this is all combinational on RXDATA.
  always_comb begin
    is_nul     = (RXDATA == ch_nul);
    is_bs      = (RXDATA == ch_bs);
    is_term    = (RXDATA == ch_cr) || (RXDATA == ch_lf);
    is_ord     = !is_nul && !is_bs && !is_term;
    has_chars  = (count != '0);
    has_room   = (count < last_idx);

    accept_ord = RXVALID && is_ord && has_room;
    drop_ord   = RXVALID && is_ord && !has_room;
    do_bs      = RXVALID && is_bs && has_chars;
    do_term    = RXVALID && is_term && has_chars;

    // Backspace echoes itself (RXDATA is already 0x08); both CR and LF
    // echo as CR.
    echo_req   = accept_ord || do_bs || do_term;
    echo_byte  = do_term ? ch_cr : RXDATA;

    xfer       = TXVALID && TXRDY;
  end

  // Write stage, character count, line length and overflow flag.
  // ADDR/DIN hold their last value when no write is issued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ADDR      <= base_addr;
      WR        <= 1'b0;
      DIN       <= 8'h00;
      LINE_DONE <= 1'b0;
      LEN       <= '0;
      OVF       <= 1'b0;
      count     <= '0;
      new_line  <= 1'b1;
    end else begin
      WR        <= accept_ord || do_term;
      LINE_DONE <= do_term;

      if (accept_ord || do_term) begin
        ADDR <= base_addr + count;
        DIN  <= do_term ? ch_nul : RXDATA;
      end

      if (accept_ord) begin
        count <= count + AddrBits'(1);
      end else if (do_bs) begin
        count <= count - AddrBits'(1);
      end else if (do_term) begin
        count <= '0;
      end

      if (do_term) begin
        LEN <= count;
      end

      if (drop_ord) begin
        OVF <= 1'b1;
      end else if (accept_ord && new_line) begin
        OVF <= 1'b0;
      end

      if (do_term) begin
        new_line <= 1'b1;
      end else if (accept_ord) begin
        new_line <= 1'b0;
      end
    end
  end

  // One-entry echo buffer. A new echo is loaded only when the slot is free
  // or is being emptied this cycle, which keeps TXDATA stable while TXVALID
  // is high; otherwise the new echo is lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      TXVALID <= 1'b0;
      TXDATA  <= 8'h00;
    end else if (echo_req && (!TXVALID || xfer)) begin
      TXVALID <= 1'b1;
      TXDATA  <= echo_byte;
    end else if (xfer) begin
      TXVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_line_writer.sv
// tb_rx_line_writer
//   Scoreboard bench for rx_line_writer. The stimulus task predicts memory
//   writes and line completions and queues them; a small echo-buffer model
//   queues the bytes the transmitter should receive. A negedge monitor pops
//   and compares whenever the DUT writes, completes a line or hands over an
//   echo byte.

module tb_rx_line_writer;

  localparam int AddrBits = 8;
  localparam int Base     = 16;
  localparam int Depth    = 4;

  logic                CLK = 1'b0;
  logic                RST;
  logic [7:0]          RXDATA;
  logic                RXVALID;
  logic [AddrBits-1:0] ADDR;
  logic                WR;
  logic [7:0]          DIN;
  logic [7:0]          TXDATA;
  logic                TXVALID;
  logic                TXRDY;
  logic                LINE_DONE;
  logic [AddrBits-1:0] LEN;
  logic                OVF;

  always #5 CLK = ~CLK;

  rx_line_writer #(
    .AddrBits(AddrBits),
    .Base    (Base),
    .Depth   (Depth)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RXDATA   (RXDATA),
    .RXVALID  (RXVALID),
    .ADDR     (ADDR),
    .WR       (WR),
    .DIN      (DIN),
    .TXDATA   (TXDATA),
    .TXVALID  (TXVALID),
    .TXRDY    (TXRDY),
    .LINE_DONE(LINE_DONE),
    .LEN      (LEN),
    .OVF      (OVF)
  );

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int len;  int ovf;  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    echo_q[$];
  wr_t   wr_item;
  done_t done_item;

  int compared   = 0;
  int mismatched = 0;

  // Reference state
  int m_count    = 0;
  bit m_ovf      = 1'b0;
  bit m_newline  = 1'b1;
  bit m_txvalid  = 1'b0;
  int m_txdata   = 0;
  bit m_xfer     = 1'b0;
  bit pend_echo  = 1'b0;
  int pend_byte  = 0;

  logic [7:0] mem [0:255];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one strobe and predicts its effect on memory, LEN/OVF and echo.
  task automatic applyStimulus(input logic [7:0] b);
    RXDATA    = b;
    RXVALID   = 1'b1;
    pend_echo = 1'b0;
    if (b == 8'h00) begin
      // ignored
    end else if (b == 8'h08) begin
      if (m_count > 0) begin
        m_count--;
        pend_echo = 1'b1;
        pend_byte = 8'h08;
      end
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (m_count > 0) begin
        wr_q.push_back('{addr: Base + m_count, data: 0});
        done_q.push_back('{len: m_count, ovf: int'(m_ovf)});
        pend_echo = 1'b1;
        pend_byte = 8'h0D;
        m_count   = 0;
        m_newline = 1'b1;
      end
    end else begin
      if (m_count < Depth - 1) begin
        wr_q.push_back('{addr: Base + m_count, data: int'(b)});
        if (m_newline) m_ovf = 1'b0;
        m_newline = 1'b0;
        m_count++;
        pend_echo = 1'b1;
        pend_byte = int'(b);
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    RXVALID   = 1'b0;
    pend_echo = 1'b0;
  endtask

  task automatic sendString(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST     = 1'b1;
    RXVALID = 1'b0;
    @(posedge CLK);
    #1;
    RST       = 1'b0;
    m_count   = 0;
    m_ovf     = 1'b0;
    m_newline = 1'b1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_addr",    ADDR,      Base);
    checkOutput("rst_wr",      WR,        0);
    checkOutput("rst_din",     DIN,       0);
    checkOutput("rst_txdata",  TXDATA,    0);
    checkOutput("rst_txvalid", TXVALID,   0);
    checkOutput("rst_done",    LINE_DONE, 0);
    checkOutput("rst_len",     LEN,       0);
    checkOutput("rst_ovf",     OVF,       0);
  endtask

  // Echo buffer model, advanced on the same edge the DUT updates.
  always @(posedge CLK) begin
    if (RST) begin
      m_txvalid = 1'b0;
      m_txdata  = 0;
    end else begin
      m_xfer = m_txvalid && (TXRDY === 1'b1);
      if (pend_echo && (!m_txvalid || m_xfer)) begin
        m_txvalid = 1'b1;
        m_txdata  = pend_byte;
      end else if (m_xfer) begin
        m_txvalid = 1'b0;
      end
    end
  end

  // Monitor: TXRDY and the registered outputs are stable here and equal to
  // what the next posedge will sample, so a transfer seen now happens then.
  always @(negedge CLK) begin
    if (m_txvalid && TXRDY === 1'b1 && RST !== 1'b1) echo_q.push_back(m_txdata);
    if (TXVALID === 1'b1 && TXRDY === 1'b1 && RST !== 1'b1) begin
      checkOutput("echo_pending", echo_q.size() > 0, 1);
      if (echo_q.size() > 0) checkOutput("echo_byte", TXDATA, echo_q.pop_front());
    end
    if (WR === 1'b1) begin
      mem[ADDR] = DIN;
      checkOutput("wr_pending", wr_q.size() > 0, 1);
      if (wr_q.size() > 0) begin
        wr_item = wr_q.pop_front();
        checkOutput("wr_addr", ADDR, wr_item.addr);
        checkOutput("wr_data", DIN, wr_item.data);
      end
    end
    if (LINE_DONE === 1'b1) begin
      checkOutput("done_with_wr", WR, 1);
      checkOutput("done_pending", done_q.size() > 0, 1);
      if (done_q.size() > 0) begin
        done_item = done_q.pop_front();
        checkOutput("done_len", LEN, done_item.len);
        checkOutput("done_ovf", OVF, done_item.ovf);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    RST     = 1'b1;
    RXDATA  = 8'h00;
    RXVALID = 1'b0;
    TXRDY   = 1'b1;
    idle(2);
    doReset();
    checkResetValues();

    // Simple line
    sendString("Hi");
    applyStimulus(8'h0D);
    idle(3);
    checkOutput("hi_mem0", mem[Base],   8'h48);
    checkOutput("hi_mem1", mem[Base+1], 8'h69);
    checkOutput("hi_mem2", mem[Base+2], 8'h00);

    // Backspace editing, LF terminator, then an empty CR LF pair
    sendString("ab");
    applyStimulus(8'h08);
    applyStimulus("c");
    applyStimulus(8'h0A);
    idle(3);
    checkOutput("bs_mem0", mem[Base],   8'h61);
    checkOutput("bs_mem1", mem[Base+1], 8'h63);
    checkOutput("bs_mem2", mem[Base+2], 8'h00);
    applyStimulus(8'h0D);
    applyStimulus(8'h0A);
    idle(3);
    checkOutput("crlf_len_hold", LEN, 2);

    // Overflow: only three characters fit before the NUL
    sendString("abcdef");
    applyStimulus(8'h0D);
    idle(3);
    checkOutput("ovf_mem0", mem[Base],   8'h61);
    checkOutput("ovf_mem1", mem[Base+1], 8'h62);
    checkOutput("ovf_mem2", mem[Base+2], 8'h63);
    checkOutput("ovf_mem3", mem[Base+3], 8'h00);
    checkOutput("ovf_sticky", OVF, 1);
    applyStimulus("x");
    checkOutput("ovf_cleared", OVF, 0);
    applyStimulus(8'h0D);
    idle(3);

    // Transmitter stalled: second echo is lost, memory still written
    TXRDY = 1'b0;
    sendString("ab");
    idle(2);
    checkOutput("stall_txvalid", TXVALID, 1);
    checkOutput("stall_txdata",  TXDATA,  8'h61);
    checkOutput("stall_mem1",    mem[Base+1], 8'h62);
    TXRDY = 1'b1;
    idle(1);
    checkOutput("stall_drained", TXVALID, 0);
    applyStimulus(8'h0D);
    idle(3);

    // Reset mid-line
    sendString("abc");
    doReset();
    checkResetValues();
    applyStimulus("z");
    applyStimulus(8'h0D);
    idle(3);
    checkOutput("rst_mem0", mem[Base],   8'h7A);
    checkOutput("rst_mem1", mem[Base+1], 8'h00);
    checkOutput("rst_len1", LEN, 1);

    // Backspace at count 0 and NULs change nothing
    applyStimulus(8'h08);
    applyStimulus(8'h00);
    idle(2);
    checkOutput("noop_txvalid", TXVALID, 0);
    applyStimulus("q");
    applyStimulus(8'h00);
    applyStimulus(8'h0D);
    idle(3);
    checkOutput("noop_mem0", mem[Base],   8'h71);
    checkOutput("noop_mem1", mem[Base+1], 8'h00);
    checkOutput("noop_len",  LEN, 1);

    idle(3);
    checkOutput("wr_q_empty",   wr_q.size(),   0);
    checkOutput("done_q_empty", done_q.size(), 0);
    checkOutput("echo_q_empty", echo_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
